// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states and shift modes.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_OR  = 4'b0000,
    OP_AND = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b1100,
    OP_SRL = 4'b1101,
    OP_SRA = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // Low two bits of the shift op codes select the shifter mode.
  typedef enum logic [1:0] {
    SH_LL = 2'b00,
    SH_RL = 2'b01,
    SH_RA = 2'b10
  } shift_mode_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_desplazador.sv
// Iterative shifter: loads operand and amount, then moves one bit per step,
// exposing the next value and the bit leaving the register on that step.
module alu_desplazador
  import alu_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [1:0]    mode_i,
  input  logic [N-1:0]  data_i,
  input  logic [CW-1:0] amt_i,
  output logic          busy_o,
  output logic          last_o,
  output logic [N-1:0]  nxt_o,
  output logic          out_bit_o
);

  logic [N-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          fill;

  always_comb begin
    fill = (mode_q == SH_RA) ? sh_q[N-1] : 1'b0;
    if (mode_q == SH_LL) begin
      nxt_o     = {sh_q[N-2:0], 1'b0};
      out_bit_o = sh_q[N-1];
    end else begin
      nxt_o     = {fill, sh_q[N-1:1]};
      out_bit_o = sh_q[0];
    end
  end

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (load_i) begin
      sh_d   = data_i;
      cnt_d  = amt_i;
      mode_d = mode_i;
    end else if (step_i && busy_o) begin
      sh_d  = nxt_o;
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == CW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      mode_q <= SH_LL;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// Registered N-bit ALU with start/ready/done handshake, stored carry for
// multi-word chaining and an iterative shifter for SLL/SRL/SRA.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [3:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  input  logic         cin_sel_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [N-1:0] result_o,
  output logic         carry_o,
  output logic         zero_o,
  output logic         neg_o,
  output logic         ovf_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] KMAX = CW'(N);

  alu_state_e   state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic         carry_q, carry_d, zero_q, zero_d;
  logic         neg_q, neg_d, ovf_q, ovf_d;
  logic         ready_q, ready_d, done_q, done_d;

  logic          accept, cin_eff;
  logic [CW-1:0] k;
  logic [N:0]    sum, diff;
  logic [N-1:0]  alu_r;
  logic          alu_c, alu_v;

  logic          sh_load, sh_step, sh_busy, sh_last, sh_out;
  logic [N-1:0]  sh_nxt;

  assign accept  = start_i && ready_q;
  assign cin_eff = cin_sel_i ? carry_q : cin_i;
  // Amounts of N or more saturate to a full shift.
  assign k = ({1'b0, b_i} >= (N+1)'(N)) ? KMAX : b_i[CW-1:0];

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_eff};
    diff  = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, cin_eff};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op_e'(op_i))
      OP_OR:  alu_r = a_i | b_i;
      OP_AND: alu_r = a_i & b_i;
      OP_XOR: alu_r = a_i ^ b_i;
      OP_ADD: begin
        alu_r = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        alu_r = diff[N-1:0];
        alu_c = diff[N];
        alu_v = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
      end
      // Only reached for zero-amount shifts: result is A, carry 0.
      OP_SLL, OP_SRL, OP_SRA: alu_r = a_i;
      default: alu_r = '0;
    endcase
  end

  alu_desplazador #(.N(N), .CW(CW)) u_desplazador (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (sh_load),
    .step_i    (sh_step),
    .mode_i    (op_i[1:0]),
    .data_i    (a_i),
    .amt_i     (k),
    .busy_o    (sh_busy),
    .last_o    (sh_last),
    .nxt_o     (sh_nxt),
    .out_bit_o (sh_out)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          if (is_shift(op_i) && (k != '0)) begin
            sh_load = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_r;
            carry_d  = alu_c;
            zero_d   = (alu_r == '0);
            neg_d    = alu_r[N-1];
            ovf_d    = alu_v;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        if (sh_last || !sh_busy) begin
          result_d = sh_nxt;
          carry_d  = sh_out;
          zero_d   = (sh_nxt == '0);
          neg_d    = sh_nxt[N-1];
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;
  assign neg_o    = neg_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo (N=8): directed table, random ops against an
// arithmetic reference model, and hand sequences for busy-start and reset.
module tb_alu_multiciclo;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, cin_i, cin_sel_i;
  logic [3:0] op_i;
  logic [7:0] a_i, b_i;
  logic       ready_o, done_o, carry_o, zero_o, neg_o, ovf_o;
  logic [7:0] result_o;

  int tests = 0;
  int fails = 0;
  logic mcarry = 1'b0;

  always #5 clk_i = ~clk_i;

  alu_multiciclo #(.N(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .cin_sel_i(cin_sel_i),
    .ready_o(ready_o), .done_o(done_o), .result_o(result_o),
    .carry_o(carry_o), .zero_o(zero_o), .neg_o(neg_o), .ovf_o(ovf_o)
  );

  typedef struct {
    string      nm;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       cin, sel;
    logic [11:0] exp;   // {result, carry, zero, neg, ovf}
    int         lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {result_o, carry_o, zero_o, neg_o, ovf_o};
  endfunction

  // Reference model from the arithmetic definition of each op.
  function automatic logic [11:0] model(input logic [3:0] op, input int a, input int b, input int cin);
    int r, c, v, k, sa, sb, s;
    r = 0; c = 0; v = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    k  = (b >= 8) ? 8 : b;
    case (op)
      4'h0: r = a | b;
      4'h1: r = a & b;
      4'h4: r = a ^ b;
      4'h3: begin
        s = a + b + cin; r = s % 256; c = s / 256;
        v = ((sa + sb + cin) > 127 || (sa + sb + cin) < -128) ? 1 : 0;
      end
      4'h2: begin
        s = a - b - cin; r = (s + 256) % 256; c = (s < 0) ? 1 : 0;
        v = ((sa - sb - cin) > 127 || (sa - sb - cin) < -128) ? 1 : 0;
      end
      4'hC: begin r = (a * (1 << k)) % 256; c = (k == 0) ? 0 : (a >> (8 - k)) & 1; end
      4'hD: begin r = a >> k; c = (k == 0) ? 0 : (a >> (k - 1)) & 1; end
      4'hE: begin r = (sa >>> k) & 255; c = (k == 0) ? 0 : (sa >>> (k - 1)) & 1; end
      default: r = 0;
    endcase
    return {r[7:0], c[0], (r == 0), r[7], v[0]};
  endfunction

  function automatic int model_lat(input logic [3:0] op, input int b);
    if (op == 4'hC || op == 4'hD || op == 4'hE)
      return (b == 0) ? 1 : 1 + ((b >= 8) ? 8 : b);
    return 1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sel,
                        output logic [11:0] got, output int lat);
    op_i = op; a_i = a; b_i = b; cin_i = cin; cin_sel_i = sel; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    op_i = 4'($urandom); a_i = 8'($urandom); b_i = 8'($urandom); cin_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_i); lat++;
    end while (!done_o && lat < 40);
    got = outs();
    @(negedge clk_i);
  endtask

  task automatic apply(input string nm, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input logic sel,
                       input logic [11:0] exp, input int elat);
    logic [11:0] got;
    int lat;
    run_op(op, a, b, cin, sel, got, lat);
    check({nm, " outs"}, 32'(got), 32'(exp));
    check({nm, " lat"}, lat, elat);
    check({nm, " ready"}, 32'(ready_o), 32'd1);
    mcarry = exp[3];
  endtask

  initial begin
    logic [3:0] ops[11];
    logic [3:0] op;
    logic [7:0] a, b;
    logic cin, sel;
    int ndone, cyc;
    logic [11:0] e;

    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'hD, 4'hE, 4'h7, 4'hF, 4'h5};
    tbl.push_back('{"add_ovf",   4'h3, 8'h7F, 8'h01, 1'b0, 1'b0, 12'h803, 1});
    tbl.push_back('{"sub_borrow",4'h2, 8'h00, 8'h01, 1'b0, 1'b0, 12'hFFA, 1});
    tbl.push_back('{"sub_ovf",   4'h2, 8'h80, 8'h01, 1'b0, 1'b0, 12'h7F1, 1});
    tbl.push_back('{"add_carry", 4'h3, 8'hFF, 8'h01, 1'b0, 1'b0, 12'h00C, 1});
    tbl.push_back('{"add_chain", 4'h3, 8'h00, 8'h00, 1'b0, 1'b1, 12'h010, 1});
    tbl.push_back('{"sra_1",     4'hE, 8'h81, 8'h01, 1'b0, 1'b0, 12'hC0A, 2});
    tbl.push_back('{"sll_3",     4'hC, 8'h81, 8'h03, 1'b0, 1'b0, 12'h080, 4});
    tbl.push_back('{"sll_9",     4'hC, 8'h81, 8'h09, 1'b0, 1'b0, 12'h00C, 9});
    tbl.push_back('{"srl_0",     4'hD, 8'h81, 8'h00, 1'b0, 1'b0, 12'h812, 1});
    tbl.push_back('{"illegal7",  4'h7, 8'h81, 8'h22, 1'b1, 1'b0, 12'h004, 1});
    tbl.push_back('{"or",        4'h0, 8'hF0, 8'h0F, 1'b0, 1'b0, 12'hFF2, 1});
    tbl.push_back('{"and",       4'h1, 8'hF0, 8'h3C, 1'b0, 1'b0, 12'h300, 1});
    tbl.push_back('{"xor",       4'h4, 8'hFF, 8'h0F, 1'b0, 1'b0, 12'hF02, 1});
    tbl.push_back('{"sra_ff",    4'hE, 8'h81, 8'hFF, 1'b0, 1'b0, 12'hFFA, 9});
    tbl.push_back('{"srl_8",     4'hD, 8'h81, 8'h08, 1'b0, 1'b0, 12'h00C, 9});
    tbl.push_back('{"sub_chain", 4'h2, 8'h05, 8'h02, 1'b0, 1'b1, 12'h020, 1});
    tbl.push_back('{"add_cin",   4'h3, 8'h7F, 8'h00, 1'b1, 1'b0, 12'h803, 1});
    tbl.push_back('{"sel_ign",   4'h3, 8'h10, 8'h20, 1'b1, 1'b1, 12'h300, 1});
    tbl.push_back('{"illegalF",  4'hF, 8'hFF, 8'hFF, 1'b1, 1'b0, 12'h004, 1});

    rst_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; cin_i = 1'b0; cin_sel_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset outs", {ready_o, done_o, outs()}, {1'b1, 1'b0, 12'h000});
    rst_i = 1'b0;
    @(negedge clk_i);

    foreach (tbl[i])
      apply(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sel,
            tbl[i].exp, tbl[i].lat);

    for (int i = 0; i < 80; i++) begin
      op  = ops[$urandom_range(0, 10)];
      a   = 8'($urandom);
      b   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      cin = 1'($urandom);
      sel = 1'($urandom);
      e = model(op, int'(a), int'(b), (sel ? int'(mcarry) : int'(cin)));
      apply($sformatf("rnd%0d_op%h", i, op), op, a, b, cin, sel, e, model_lat(op, int'(b)));
    end

    // start pulsed while shifting must be ignored
    op_i = 4'hC; a_i = 8'h81; b_i = 8'h04; cin_i = 1'b0; cin_sel_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    op_i = 4'h3; a_i = 8'h01; b_i = 8'h01;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (done_o) ndone++;
      start_i = (c < 3);
    end
    start_i = 1'b0;
    check("busy start dones", ndone, 1);
    check("busy start outs", 32'(outs()), 32'h100);

    // hold: outputs unchanged while idle with inputs wiggling
    a_i = 8'h55; b_i = 8'h66; op_i = 4'h3;
    repeat (3) @(negedge clk_i);
    check("hold outs", 32'(outs()), 32'h100);

    // reset mid-shift, after a result with nonzero flags
    apply("pre_rst", 4'h3, 8'hFF, 8'h02, 1'b0, 1'b0, 12'h018, 1);
    op_i = 4'hC; a_i = 8'hFF; b_i = 8'h07; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1; #1;
    check("async rst", {ready_o, done_o, outs()}, {1'b1, 1'b0, 12'h000});
    @(negedge clk_i);
    rst_i = 1'b0;
    mcarry = 1'b0;
    ndone = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    check("post rst done", ndone, 0);
    check("post rst ready", 32'(ready_o), 32'd1);
    apply("post_rst_chain", 4'h3, 8'h01, 8'h01, 1'b1, 1'b1, 12'h020, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
